// File: rtl/adc_pkg.sv
// Shared types and defaults for the SAR ADC sequencer and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_pkg;

    // Default resolution and phase lengths; SETTLE must cover DAC/R2R
    // settling plus the two comparator synchronizer stages.
    localparam int ADC_WIDTH         = 8;
    localparam int ADC_SAMPLE_CYCLES = 8;
    localparam int ADC_SETTLE_CYCLES = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_TRIAL  = 2'd2,
        S_DONE   = 2'd3
    } adc_state_t;

    // Width of a counter that holds 0..n-1; never narrower than one bit so
    // that a parameter value of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comp_sync.sv
// Two-flop synchronizer for asynchronous digital inputs, reset to 0.
// Latency: 2 clk cycles from input change to o_sync.
// Backpressure: none; samples every cycle.
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_async  asynchronous input bits
//   o_sync   synchronized copy of i_async
module comp_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/sar_adc_control.sv
// Successive-approximation ADC sequencer driving the R2R DAC code and
// binary-searching the synchronized comparator into a WIDTH-bit result.
// Latency: start edge k -> o_done in cycle k+1+SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES.
// Backpressure: none; start while busy is dropped, not queued.
//
// Ports:
//   i_clk         system clock (10 MHz nominal)
//   i_rst         synchronous active-high reset
//   i_start       begin a conversion (only looked at in IDLE)
//   i_continuous  chain conversions back-to-back (only looked at in DONE)
//   i_comp_in     asynchronous comparator, 1 = Vin >= Vdac
//   o_dac_code    trial code to the R2R DAC drivers
//   o_sample_en   track/hold switch, high = track
//   o_busy        high whenever not IDLE
//   o_done        one-cycle pulse when o_result updates
//   o_result      last completed conversion
module sar_adc_control
    import adc_pkg::*;
#(
    parameter int WIDTH         = ADC_WIDTH,
    parameter int SAMPLE_CYCLES = ADC_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = ADC_SETTLE_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic             i_comp_in,
    output logic [WIDTH-1:0] o_dac_code,
    output logic             o_sample_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int SW = cnt_width(SAMPLE_CYCLES);
    localparam int TW = cnt_width(SETTLE_CYCLES);
    localparam int BW = cnt_width(WIDTH);

    localparam logic [SW-1:0]    SMP_LAST = SW'(SAMPLE_CYCLES - 1);
    localparam logic [TW-1:0]    SET_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0]    BIT_MSB  = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Comparator synchronizer
    // ------------------------------------------------------------------
    logic w_comp_s;

    comp_sync #(
        .WIDTH (1)
    ) u_comp_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_comp_in),
        .o_sync  (w_comp_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    adc_state_t       r_state;
    logic [SW-1:0]    r_smp_cnt;
    logic [TW-1:0]    r_set_cnt;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] r_result;
    logic             r_sample_en;
    logic             r_busy;
    logic             r_done;

    adc_state_t       w_state_nxt;
    logic [SW-1:0]    w_smp_nxt;
    logic [TW-1:0]    w_set_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic [WIDTH-1:0] w_code_nxt;
    logic [WIDTH-1:0] w_result_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_smp_cnt   <= '0;
            r_set_cnt   <= '0;
            r_bit       <= '0;
            r_code      <= '0;
            r_result    <= '0;
            r_sample_en <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_smp_cnt   <= w_smp_nxt;
            r_set_cnt   <= w_set_nxt;
            r_bit       <= w_bit_nxt;
            r_code      <= w_code_nxt;
            r_result    <= w_result_nxt;
            // Control outputs come straight from flops so the track/hold
            // switch never sees decode glitches.
            r_sample_en <= (w_state_nxt == S_SAMPLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_smp_nxt    = r_smp_cnt;
        w_set_nxt    = r_set_cnt;
        w_bit_nxt    = r_bit;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;

        case (r_state)
            S_IDLE: begin
                // dac_code deliberately holds its last value while idle.
                if (i_start) begin
                    w_state_nxt = S_SAMPLE;
                    w_smp_nxt   = '0;
                    w_code_nxt  = '0;
                end
            end

            S_SAMPLE: begin
                if (r_smp_cnt == SMP_LAST) begin
                    w_state_nxt = S_TRIAL;
                    w_smp_nxt   = '0;
                    w_set_nxt   = '0;
                    w_bit_nxt   = BIT_MSB;
                    w_code_nxt  = CODE_MSB;
                end else begin
                    w_smp_nxt = r_smp_cnt + 1'b1;
                end
            end

            S_TRIAL: begin
                if (r_set_cnt == SET_LAST) begin
                    // Decide the current bit and, in the same update, raise
                    // the next lower bit as the following trial.
                    w_set_nxt         = '0;
                    w_code_nxt[r_bit] = w_comp_s;
                    if (r_bit != '0) begin
                        w_code_nxt[r_bit - 1'b1] = 1'b1;
                        w_bit_nxt                = r_bit - 1'b1;
                    end else begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = w_code_nxt;
                    end
                end else begin
                    w_set_nxt = r_set_cnt + 1'b1;
                end
            end

            S_DONE: begin
                if (i_continuous) begin
                    w_state_nxt = S_SAMPLE;
                    w_smp_nxt   = '0;
                    w_code_nxt  = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_dac_code  = r_code;
    assign o_sample_en = r_sample_en;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_result    = r_result;

endmodule

// File: tb/tb_sar_adc_control.sv
// Self-checking bench for sar_adc_control: table of single conversions plus
// hand-written continuous, start-while-busy, reset-abort and noisy-comparator
// sequences. Comparator model: comp_in = (vin >= dac_code).
module tb_sar_adc_control;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic       comp_in;
    logic [7:0] dac_code;
    logic       sample_en;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic [7:0] vin;
    bit         async_mode;
    logic       comp_async;
    int         xcnt;

    int total;
    int bad;

    sar_adc_control dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_continuous (cont),
        .i_comp_in    (comp_in),
        .o_dac_code   (dac_code),
        .o_sample_en  (sample_en),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign comp_in = async_mode ? comp_async : (vin >= dac_code);

    // Noisy comparator: updates at random phase, and is undecided (random)
    // exactly at the threshold code.
    initial comp_async = 1'b0;
    always begin
        #($urandom_range(1, 7));
        if (async_mode) begin
            if (dac_code == vin) comp_async = 1'($urandom_range(0, 1));
            else                 comp_async = (vin >= dac_code);
        end
    end

    always @(negedge clk) begin
        if (async_mode && $isunknown(dut.w_comp_s)) xcnt++;
    end

    typedef struct {
        logic [7:0]      vin;
        logic [7:0]      exp_res;
        logic [7:0][7:0] exp_tr;   // first trial in the top byte
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One conversion from a start pulse; observes cycles 1..45 after the
    // start edge. Optional extra start pulses at cycles 10 and 30.
    task automatic conv(input logic [7:0] v, input bit glitch,
                        output int done_cyc, output int done_n,
                        output int busy_in, output int busy_out,
                        output int se_n, output int se_last,
                        output logic [7:0][7:0] tr, output logic [7:0] res);
        int idx;
        done_cyc = -1; done_n = 0; busy_in = 0; busy_out = 0;
        se_n = 0; se_last = -1; tr = '0; res = '0; idx = 0;
        vin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                done_n++;
                if (done_n == 1) begin
                    done_cyc = c;
                    res      = result;
                end
            end
            if (busy && c <= 41) busy_in++;
            if (busy && c > 41)  busy_out++;
            if (sample_en) begin
                se_n++;
                se_last = c;
            end
            if (c >= 9 && ((c - 9) % 4) == 0 && idx < 8) begin
                tr[7 - idx] = dac_code;
                idx++;
            end
            start = (glitch && (c == 10 || c == 30)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int done_cyc, done_n, busy_in, busy_out, se_n, se_last;
        logic [7:0][7:0] tr;
        logic [7:0] res;
        int ndone, d1, d2, idle_gap, b83;
        logic [7:0] r1, r2;
        int diff;

        total = 0; bad = 0; xcnt = 0;
        async_mode = 1'b0;
        vin = 8'h00; start = 1'b0; cont = 1'b0; rst = 1'b1;

        vecs[0] = '{8'h5A, 8'h5A, {8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B}};
        vecs[1] = '{8'hFF, 8'hFF, {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF}};
        vecs[2] = '{8'h00, 8'h00, {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
        vecs[3] = '{8'h33, 8'h33, {8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h34, 8'h32, 8'h33}};
        vecs[4] = '{8'h01, 8'h01, {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
        vecs[5] = '{8'h80, 8'h80, {8'h80, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dac_code",  int'(dac_code),  0);
        chk("rst_sample_en", int'(sample_en), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_done",      int'(done),      0);
        chk("rst_result",    int'(result),    0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of single conversions
        foreach (vecs[n]) begin
            conv(vecs[n].vin, 1'b0, done_cyc, done_n, busy_in, busy_out,
                 se_n, se_last, tr, res);
            chk($sformatf("v%0d_done_cycle", n), done_cyc, 41);
            chk($sformatf("v%0d_done_count", n), done_n, 1);
            chk($sformatf("v%0d_result", n), int'(res), int'(vecs[n].exp_res));
            chk($sformatf("v%0d_busy_cycles", n), busy_in, 41);
            chk($sformatf("v%0d_busy_after", n), busy_out, 0);
            chk($sformatf("v%0d_sample_cycles", n), se_n, 8);
            chk($sformatf("v%0d_sample_last", n), se_last, 8);
            for (int j = 0; j < 8; j++)
                chk($sformatf("v%0d_trial%0d", n, 7 - j), int'(tr[j]), int'(vecs[n].exp_tr[j]));
            chk($sformatf("v%0d_idle_hold", n), int'(dac_code), int'(vecs[n].exp_res));
        end

        // Start while busy is ignored
        conv(8'h33, 1'b1, done_cyc, done_n, busy_in, busy_out, se_n, se_last, tr, res);
        chk("glitch_done_count", done_n, 1);
        chk("glitch_done_cycle", done_cyc, 41);
        chk("glitch_result", int'(res), 8'h33);
        chk("glitch_busy_after", busy_out, 0);

        // Continuous mode, input changes between conversions, then drop
        // continuous mid-way through the second conversion.
        ndone = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0; idle_gap = 0; b83 = -1;
        vin = 8'h10; cont = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 95; c++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = c; r1 = result; end
                else if (ndone == 2) begin d2 = c; r2 = result; end
            end
            if (c <= 82 && !busy) idle_gap++;
            if (c == 83) b83 = int'(busy);
            if (c == 41) vin = 8'hC4;
            if (c == 45) cont = 1'b0;
            @(posedge clk); #1;
        end
        chk("cont_done1_cycle", d1, 41);
        chk("cont_result1", int'(r1), 8'h10);
        chk("cont_done2_cycle", d2, 82);
        chk("cont_result2", int'(r2), 8'hC4);
        chk("cont_done_count", ndone, 2);
        chk("cont_idle_gap", idle_gap, 0);
        chk("cont_busy_after", b83, 0);

        // Reset in the middle of a trial
        vin = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", int'(busy), 1);
        chk("abort_sample_before", int'(sample_en), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_dac_code", int'(dac_code), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sample_en", int'(sample_en), 0);
        ndone = 0; b83 = 0;
        for (int c = 0; c < 45; c++) begin
            if (done) ndone++;
            if (busy) b83++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_stays_idle", b83, 0);
        conv(8'h5A, 1'b0, done_cyc, done_n, busy_in, busy_out, se_n, se_last, tr, res);
        chk("after_abort_result", int'(res), 8'h5A);
        chk("after_abort_done_cycle", done_cyc, 41);

        // Random-phase, threshold-noisy comparator
        async_mode = 1'b1;
        for (int n = 0; n < 50; n++) begin
            conv(8'h40, 1'b0, done_cyc, done_n, busy_in, busy_out, se_n, se_last, tr, res);
            diff = int'(res) - 'h40;
            chk($sformatf("async%0d_within_1lsb", n), int'(diff >= -1 && diff <= 1), 1);
        end
        async_mode = 1'b0;
        chk("async_comp_s_x_cycles", xcnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
